// File: rtl/pe_dot_accum_4xpack.sv
// pe_dot_accum_4xpack: reduces 4x-packed sign-magnitude products per lane, accumulates first..last runs,
// and presents results via a valid/ready register. Define PE_DOT_ACCUM_SAT_EN for saturating accumulation.
module pe_dot_accum_4xpack #(
    parameter int DOT_SIZE          = 8,
    parameter int MULT_OUTPUT_WIDTH = 9,
    parameter int MULT_LATENCY      = 3,
    parameter int ACCUM_WIDTH       = 24
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   i_valid,
    input  logic                                                   i_first,
    input  logic                                                   i_last,
    input  logic [1:0][1:0][DOT_SIZE-1:0][MULT_OUTPUT_WIDTH-1:0] i_mult_output,
    input  logic                                                   i_ready,
    output logic                                                   o_valid,
    output logic [1:0][1:0][ACCUM_WIDTH-1:0]                       o_result,
    output logic                                                   o_overflow
);
    localparam int MW = MULT_OUTPUT_WIDTH;
    localparam int AW = ACCUM_WIDTH;

    logic [MULT_LATENCY-1:0] r_dv, r_df, r_dl;
    logic r_a_vld, r_a_first, r_a_last, r_b_vld, r_b_first, r_b_last;
    logic [1:0][1:0][DOT_SIZE-1:0][AW-1:0] w_a, r_a;
    logic [1:0][1:0][AW-1:0] w_b, r_b, r_acc, w_acc_next;
    logic w_load;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dv <= '0;
            r_df <= '0;
            r_dl <= '0;
        end else begin
            r_dv[0] <= i_valid;
            r_df[0] <= i_first;
            r_dl[0] <= i_last;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                r_dv[i] <= r_dv[i-1];
                r_df[i] <= r_df[i-1];
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    always_comb begin
        w_a = '0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < DOT_SIZE; i++)
                    w_a[f][k][i] = i_mult_output[f][k][i][MW-1] ? AW'(0) - AW'(i_mult_output[f][k][i][MW-2:0])
                                                                 : AW'(i_mult_output[f][k][i][MW-2:0]);
    end

    always_comb begin
        w_b = '0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < DOT_SIZE; i++)
                    w_b[f][k] = w_b[f][k] + r_a[f][k][i];
    end

    always_ff @(posedge clock) begin
        r_a <= w_a;
        r_b <= w_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_vld   <= 1'b0;
            r_a_first <= 1'b0;
            r_a_last  <= 1'b0;
            r_b_vld   <= 1'b0;
            r_b_first <= 1'b0;
            r_b_last  <= 1'b0;
        end else begin
            r_a_vld   <= r_dv[MULT_LATENCY-1];
            r_a_first <= r_df[MULT_LATENCY-1];
            r_a_last  <= r_dl[MULT_LATENCY-1];
            r_b_vld   <= r_a_vld;
            r_b_first <= r_a_first;
            r_b_last  <= r_a_last;
        end
    end

`ifdef PE_DOT_ACCUM_SAT_EN
    logic [1:0][1:0] r_sat, w_sat_next;
    logic [AW:0] w_wide;

    // once a lane clips it holds the limit until the next first vector
    always_comb begin
        w_acc_next = r_acc;
        w_sat_next = r_sat;
        w_wide     = '0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                w_wide = {r_acc[f][k][AW-1], r_acc[f][k]} + {r_b[f][k][AW-1], r_b[f][k]};
                if (r_b_first) begin
                    w_acc_next[f][k] = r_b[f][k];
                    w_sat_next[f][k] = 1'b0;
                end else if (!r_sat[f][k]) begin
                    w_sat_next[f][k] = w_wide[AW] != w_wide[AW-1];
                    w_acc_next[f][k] = (w_wide[AW] == w_wide[AW-1]) ? w_wide[AW-1:0] :
                                       w_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                end
            end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_sat <= '0;
        else if (r_b_vld)
            r_sat <= w_sat_next;
    end
`else
    always_comb begin
        w_acc_next = '0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++)
                w_acc_next[f][k] = r_b_first ? r_b[f][k] : r_acc[f][k] + r_b[f][k];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset)
            r_acc <= '0;
        else if (r_b_vld)
            r_acc <= w_acc_next;
    end

    assign w_load = r_b_vld & r_b_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
        end else if (w_load && (!o_valid || i_ready)) begin
            o_valid  <= 1'b1;
            o_result <= w_acc_next;
        end else if (w_load) begin
            o_overflow <= 1'b1;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pe_dot_accum_4xpack.sv
// tb_pe_dot_accum_4xpack: directed scenarios for pe_dot_accum_4xpack; products are fed through a
// bench-side delay so they arrive MULT_LATENCY cycles after the sideband flags.
module tb_pe_dot_accum_4xpack;
    localparam int DS = 8;
    localparam int MW = 9;
    localparam int ML = 3;
`ifdef PE_DOT_ACCUM_SAT_EN
    localparam int AW = 12;
`else
    localparam int AW = 24;
`endif

    typedef logic [1:0][1:0][DS-1:0][MW-1:0] prod_t;

    logic clock = 1'b0;
    logic reset, i_valid, i_first, i_last, i_ready;
    logic o_valid, o_overflow;
    logic [1:0][1:0][AW-1:0] o_result;
    prod_t pin, d0, d1, d2;
    int tests = 0;
    int fails = 0;

    pe_dot_accum_4xpack #(
        .DOT_SIZE(DS), .MULT_OUTPUT_WIDTH(MW), .MULT_LATENCY(ML), .ACCUM_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
        .i_mult_output(d2), .i_ready(i_ready), .o_valid(o_valid), .o_result(o_result),
        .o_overflow(o_overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        d0 <= pin;
        d1 <= d0;
        d2 <= d1;
    end

    function automatic prod_t fill(input logic s, input int m);
        prod_t p;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < DS; i++)
                    p[f][k][i] = {s, 8'(m)};
        return p;
    endfunction

    task automatic issue(input logic f, input logic l, input prod_t p);
        i_valid = 1'b1;
        i_first = f;
        i_last  = l;
        pin     = p;
        @(posedge clock); #1;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 1;
        while (!o_valid && cnt < 40) begin
            @(posedge clock); #1;
            cnt++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        tests++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: o_valid=%b o_overflow=%b expected 0 0", o_valid, o_overflow);
        end
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_result[f][k] !== AW'(0)) begin
                    fails++;
                    $display("FAIL reset_result[%0d][%0d]: got %0d expected 0", f, k, $signed(o_result[f][k]));
                end
            end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic;
        int cnt;
        issue(1'b1, 1'b1, fill(1'b0, 3));
        wait_valid(cnt);
        tests++;
        if (cnt !== ML + 3) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles expected %0d", cnt, ML + 3);
        end
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_result[f][k] !== AW'(24)) begin
                    fails++;
                    $display("FAIL basic_result[%0d][%0d]: got %0d expected 24", f, k, $signed(o_result[f][k]));
                end
            end
        idle(1);
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_one_cycle: o_valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_multi;
        int cnt;
        int e[2][2];
        prod_t p;
        e = '{'{-1176, 24}, '{24, 24}};
        p = fill(1'b0, 1);
        for (int i = 0; i < DS; i++) p[0][0][i] = {1'b1, 8'd49};
        issue(1'b1, 1'b0, p);
        issue(1'b0, 1'b0, p);
        issue(1'b0, 1'b1, p);
        wait_valid(cnt);
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL multi_timeout: o_valid=%b expected 1", o_valid);
        end
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_result[f][k] !== AW'(e[f][k])) begin
                    fails++;
                    $display("FAIL multi_result[%0d][%0d]: got %0d expected %0d", f, k, $signed(o_result[f][k]), e[f][k]);
                end
            end
        idle(2);
    endtask

    task automatic test_neg_zero;
        int cnt;
        issue(1'b1, 1'b1, fill(1'b1, 0));
        wait_valid(cnt);
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL negzero_timeout: o_valid=%b expected 1", o_valid);
        end
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_result[f][k] !== AW'(0)) begin
                    fails++;
                    $display("FAIL negzero_result[%0d][%0d]: got %0d expected 0", f, k, $signed(o_result[f][k]));
                end
            end
        idle(2);
    endtask

    task automatic test_overflow;
        int cnt;
        i_ready = 1'b0;
        issue(1'b1, 1'b1, fill(1'b0, 1));
        issue(1'b1, 1'b1, fill(1'b0, 2));
        wait_valid(cnt);
        idle(3);
        tests++;
        if (o_valid !== 1'b1 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flags: o_valid=%b o_overflow=%b expected 1 1", o_valid, o_overflow);
        end
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_result[f][k] !== AW'(8)) begin
                    fails++;
                    $display("FAIL ovf_held[%0d][%0d]: got %0d expected 8", f, k, $signed(o_result[f][k]));
                end
            end
        i_ready = 1'b1;
        idle(1);
        tests++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_accept: o_valid=%b o_overflow=%b expected 0 1", o_valid, o_overflow);
        end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        tests++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: o_overflow=%b expected 0", o_overflow);
        end
    endtask

    task automatic test_back_to_back;
        int cnt;
        i_ready = 1'b1;
        issue(1'b1, 1'b1, fill(1'b0, 1));
        issue(1'b1, 1'b1, fill(1'b0, 2));
        wait_valid(cnt);
        tests++;
        if (o_valid !== 1'b1 || o_result[1][0] !== AW'(8)) begin
            fails++;
            $display("FAIL b2b_first: o_valid=%b result=%0d expected 1 8", o_valid, $signed(o_result[1][0]));
        end
        idle(1);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_valid !== 1'b1 || o_result[f][k] !== AW'(16)) begin
                    fails++;
                    $display("FAIL b2b_second[%0d][%0d]: o_valid=%b got %0d expected 1 16", f, k, o_valid, $signed(o_result[f][k]));
                end
            end
        tests++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_overflow: o_overflow=%b expected 0", o_overflow);
        end
        idle(1);
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: o_valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_reset_mid;
        int cnt;
        issue(1'b1, 1'b0, fill(1'b0, 5));
        issue(1'b0, 1'b0, fill(1'b0, 5));
        idle(6);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        issue(1'b0, 1'b1, fill(1'b0, 1));
        wait_valid(cnt);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_valid !== 1'b1 || o_result[f][k] !== AW'(8)) begin
                    fails++;
                    $display("FAIL rstmid_nonfirst[%0d][%0d]: o_valid=%b got %0d expected 1 8", f, k, o_valid, $signed(o_result[f][k]));
                end
            end
        idle(2);
        issue(1'b1, 1'b1, fill(1'b0, 1));
        wait_valid(cnt);
        tests++;
        if (o_valid !== 1'b1 || o_result[0][1] !== AW'(8)) begin
            fails++;
            $display("FAIL rstmid_first: o_valid=%b got %0d expected 1 8", o_valid, $signed(o_result[0][1]));
        end
        idle(2);
    endtask

`ifdef PE_DOT_ACCUM_SAT_EN
    task automatic test_sat;
        int cnt;
        issue(1'b1, 1'b0, fill(1'b0, 49));
        repeat (4) issue(1'b0, 1'b0, fill(1'b0, 49));
        issue(1'b0, 1'b1, fill(1'b0, 49));
        wait_valid(cnt);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_valid !== 1'b1 || o_result[f][k] !== AW'(2047)) begin
                    fails++;
                    $display("FAIL sat[%0d][%0d]: o_valid=%b got %0d expected 1 2047", f, k, o_valid, $signed(o_result[f][k]));
                end
            end
        idle(2);
    endtask
`endif

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        pin     = '0;
        test_reset();
        test_basic();
        test_multi();
        test_neg_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef PE_DOT_ACCUM_SAT_EN
        test_sat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
